// File: rtl/blackparrot_fpga_host_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : blackparrot_fpga_host_cmd_arbiter
// Purpose : Shares one fifo-to-AXI command path between the NBF loader (r0)
//           and the host MMIO port (r1). Order FIFOs route responses back.
//           A quiesce FSM drains outstanding traffic.
// Option  : BLACKPARROT_FPGA_HOST_CMD_ARB_FIXED_PRIO_EN -> r0 always wins ties
// Rev     : 1.0  initial release
// ============================================================================
module blackparrot_fpga_host_cmd_arbiter #(
  parameter int addr_width_p = 64,
  parameter int data_width_p = 64,
  parameter int credits_p    = 64
) (
  input  logic                    m_axi_aclk,
  input  logic                    m_axi_aresetn,
  input  logic                    r0_v_i,
  input  logic                    r0_w_i,
  input  logic [addr_width_p-1:0] r0_addr_i,
  input  logic [data_width_p-1:0] r0_data_i,
  input  logic [2:0]              r0_size_i,
  output logic                    r0_ready_and_o,
  output logic                    r0_wr_done_o,
  output logic                    r0_rd_v_o,
  output logic [data_width_p-1:0] r0_rd_data_o,
  input  logic                    r0_rd_ready_and_i,
  input  logic                    r1_v_i,
  input  logic                    r1_w_i,
  input  logic [addr_width_p-1:0] r1_addr_i,
  input  logic [data_width_p-1:0] r1_data_i,
  input  logic [2:0]              r1_size_i,
  output logic                    r1_ready_and_o,
  output logic                    r1_wr_done_o,
  output logic                    r1_rd_v_o,
  output logic [data_width_p-1:0] r1_rd_data_o,
  input  logic                    r1_rd_ready_and_i,
  output logic                    cmd_v_o,
  output logic                    cmd_w_o,
  output logic [addr_width_p-1:0] cmd_addr_o,
  output logic [data_width_p-1:0] cmd_data_o,
  output logic [2:0]              cmd_size_o,
  input  logic                    cmd_ready_and_i,
  input  logic                    wr_done_v_i,
  input  logic                    rd_v_i,
  input  logic [data_width_p-1:0] rd_data_i,
  output logic                    rd_ready_and_o,
  input  logic                    quiesce_i,
  output logic                    quiesce_done_o,
  output logic                    err_o
);

  localparam int PTR_W = (credits_p > 1) ? $clog2(credits_p) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_QUIET = 2'd2;

  logic       live;
  logic [1:0] state, state_nxt;
  logic       run;
  logic       lock, lock_nxt, lock_id;
  logic       sel, sel_v, sel_w, pick_both;
  logic       grant_en, cmd_v, hs;
  // index 0 = write-order FIFO, index 1 = read-order FIFO
  logic [1:0] push, pop, full, empty, head, drained;

  // Combinational outputs are forced low while reset is held.
  assign live = m_axi_aresetn;

`ifdef BLACKPARROT_FPGA_HOST_CMD_ARB_FIXED_PRIO_EN
  assign pick_both = 1'b0;
`else
  logic rr_last;
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) rr_last <= 1'b1;
    else if (hs)        rr_last <= sel;
  end
  assign pick_both = ~rr_last;
`endif

  always_comb begin
    sel = pick_both;
    if (lock)                  sel = lock_id;
    else if (r0_v_i ^ r1_v_i)  sel = r1_v_i;
  end

  assign sel_v    = sel ? r1_v_i : r0_v_i;
  assign sel_w    = sel ? r1_w_i : r0_w_i;
  assign grant_en = run & ~(sel_w ? full[0] : full[1]);
  assign cmd_v    = live & sel_v & grant_en;
  assign hs       = cmd_v & cmd_ready_and_i;
  assign lock_nxt = (cmd_v & ~cmd_ready_and_i) | (lock & ~hs);

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      lock    <= 1'b0;
      lock_id <= 1'b0;
    end else begin
      lock <= lock_nxt;
      if (cmd_v & ~cmd_ready_and_i) lock_id <= sel;
    end
  end

  assign push[0] = hs & sel_w;
  assign push[1] = hs & ~sel_w;
  assign rd_ready_and_o = live & (empty[1] | (head[1] ? r1_rd_ready_and_i : r0_rd_ready_and_i));
  assign pop[0]  = live & wr_done_v_i & ~empty[0];
  assign pop[1]  = live & rd_v_i & ~empty[1] & rd_ready_and_o;

  for (genvar c = 0; c < 2; c++) begin : g_fifo
    logic [PTR_W-1:0] wptr, rptr;
    logic [CNT_W-1:0] count, count_nxt;
    logic             mem [credits_p];

    assign count_nxt  = count + CNT_W'(push[c]) - CNT_W'(pop[c]);
    assign full[c]    = (count == CNT_W'(credits_p));
    assign empty[c]   = (count == '0);
    assign drained[c] = (count_nxt == '0);
    assign head[c]    = mem[rptr];

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
      if (!m_axi_aresetn) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else begin
        if (push[c]) wptr <= wptr + 1'b1;
        if (pop[c])  rptr <= rptr + 1'b1;
        count <= count_nxt;
      end
    end

    always_ff @(posedge m_axi_aclk) begin
      if (push[c]) mem[wptr] <= sel;
    end
  end

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) state <= ST_RUN;
    else                state <= state_nxt;
  end

  // Entering DRAIN waits for any locked transfer so it is never stranded.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:   if (quiesce_i && !lock_nxt) state_nxt = ST_DRAIN;
      ST_DRAIN: if (!quiesce_i) state_nxt = ST_RUN;
                else if (&drained) state_nxt = ST_QUIET;
      ST_QUIET: if (!quiesce_i) state_nxt = ST_RUN;
      default:  state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    run            = (state == ST_RUN);
    quiesce_done_o = (state == ST_QUIET);
  end

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) err_o <= 1'b0;
    else if ((wr_done_v_i && empty[0]) || (rd_v_i && empty[1])) err_o <= 1'b1;
  end

  assign cmd_v_o        = cmd_v;
  assign cmd_w_o        = live & sel_w;
  assign cmd_addr_o     = live ? (sel ? r1_addr_i : r0_addr_i) : '0;
  assign cmd_data_o     = live ? (sel ? r1_data_i : r0_data_i) : '0;
  assign cmd_size_o     = live ? (sel ? r1_size_i : r0_size_i) : '0;
  assign r0_ready_and_o = hs & ~sel;
  assign r1_ready_and_o = hs & sel;
  assign r0_wr_done_o   = pop[0] & ~head[0];
  assign r1_wr_done_o   = pop[0] & head[0];
  assign r0_rd_v_o      = live & rd_v_i & ~empty[1] & ~head[1];
  assign r1_rd_v_o      = live & rd_v_i & ~empty[1] & head[1];
  assign r0_rd_data_o   = live ? rd_data_i : '0;
  assign r1_rd_data_o   = live ? rd_data_i : '0;

endmodule
`default_nettype wire

// File: tb/tb_blackparrot_fpga_host_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_blackparrot_fpga_host_cmd_arbiter
// Purpose : Randomized traffic against a queue-based reference model with a
//           per-requester response scoreboard. Rev 1.0
// ============================================================================
module tb_blackparrot_fpga_host_cmd_arbiter;
  localparam int AW = 64, DW = 64, CRED = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  logic rv[2], rw[2], rrdy[2];
  logic [AW-1:0] ra[2];
  logic [DW-1:0] rdt[2];
  logic [2:0] rsz[2];
  logic rdy_o[2], wrd_o[2], rdv_o[2];
  logic [DW-1:0] rdd_o[2];
  logic cmd_v_o, cmd_w_o, cmd_ready, wr_done_v, rd_v, rd_ready_o, quiesce, qdone, err;
  logic [AW-1:0] cmd_addr_o;
  logic [DW-1:0] cmd_data_o, rd_data;
  logic [2:0] cmd_size_o;
  int total = 0, bad = 0;

  // reference model
  bit m_last = 1'b1, m_lock = 1'b0, m_lock_id = 1'b0, m_err = 1'b0;
  int m_mode = 0;  // 0 run, 1 drain, 2 quiet
  bit wq[$], rq[$];
  // scoreboard and bridge model
  int exp_wr[2] = '{0, 0};
  logic [DW-1:0] exp_rd0[$], exp_rd1[$];
  int bw = 0;
  logic [AW-1:0] br[$];
  bit acc[2] = '{0, 0};
  bit stop_new = 1'b0, force_wr = 1'b0;

  blackparrot_fpga_host_cmd_arbiter #(
    .addr_width_p(AW), .data_width_p(DW), .credits_p(CRED)
  ) dut (
    .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
    .r0_v_i(rv[0]), .r0_w_i(rw[0]), .r0_addr_i(ra[0]), .r0_data_i(rdt[0]), .r0_size_i(rsz[0]),
    .r0_ready_and_o(rdy_o[0]), .r0_wr_done_o(wrd_o[0]), .r0_rd_v_o(rdv_o[0]),
    .r0_rd_data_o(rdd_o[0]), .r0_rd_ready_and_i(rrdy[0]),
    .r1_v_i(rv[1]), .r1_w_i(rw[1]), .r1_addr_i(ra[1]), .r1_data_i(rdt[1]), .r1_size_i(rsz[1]),
    .r1_ready_and_o(rdy_o[1]), .r1_wr_done_o(wrd_o[1]), .r1_rd_v_o(rdv_o[1]),
    .r1_rd_data_o(rdd_o[1]), .r1_rd_ready_and_i(rrdy[1]),
    .cmd_v_o(cmd_v_o), .cmd_w_o(cmd_w_o), .cmd_addr_o(cmd_addr_o), .cmd_data_o(cmd_data_o),
    .cmd_size_o(cmd_size_o), .cmd_ready_and_i(cmd_ready),
    .wr_done_v_i(wr_done_v), .rd_v_i(rd_v), .rd_data_i(rd_data), .rd_ready_and_o(rd_ready_o),
    .quiesce_i(quiesce), .quiesce_done_o(qdone), .err_o(err)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] hash(input logic [63:0] a);
    return {a[31:0], a[63:32]} ^ (a * 64'h9E37_79B9_7F4A_7C15);
  endfunction

  function automatic bit any_out();
    return cmd_v_o | cmd_w_o | (|cmd_addr_o) | (|cmd_data_o) | (|cmd_size_o) |
           rdy_o[0] | rdy_o[1] | wrd_o[0] | wrd_o[1] | rdv_o[0] | rdv_o[1] |
           (|rdd_o[0]) | (|rdd_o[1]) | rd_ready_o | qdone | err;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  // Monitor: checks every output, retires responses, then advances the model.
  always @(negedge clk) begin
    bit s, ev, hs, erd, e;
    if (!rst_n) begin
      chk("reset_outputs_zero", any_out(), 0);
      m_last = 1'b1; m_lock = 1'b0; m_lock_id = 1'b0; m_err = 1'b0; m_mode = 0;
      wq.delete(); rq.delete(); exp_rd0.delete(); exp_rd1.delete(); br.delete();
      exp_wr[0] = 0; exp_wr[1] = 0; bw = 0; acc[0] = 0; acc[1] = 0;
    end else begin
      if (m_lock) s = m_lock_id;
      else if (rv[0] && rv[1]) begin
`ifdef BLACKPARROT_FPGA_HOST_CMD_ARB_FIXED_PRIO_EN
        s = 1'b0;
`else
        s = !m_last;
`endif
      end else s = rv[1];
      ev = rv[s] && (m_mode == 0) && (rw[s] ? (wq.size() < CRED) : (rq.size() < CRED));
      hs = ev && cmd_ready;
      chk("cmd_v", cmd_v_o, ev);
      if (ev) begin
        chk("cmd_w", cmd_w_o, rw[s]);
        chk("cmd_addr", cmd_addr_o, ra[s]);
        chk("cmd_data", cmd_data_o, rdt[s]);
        chk("cmd_size", cmd_size_o, rsz[s]);
      end
      erd = (rq.size() == 0) ? 1'b1 : rrdy[rq[0]];
      chk("rd_ready", rd_ready_o, erd);
      for (int n = 0; n < 2; n++) begin
        chk("req_ready", rdy_o[n], hs && (s == n));
        e = wr_done_v && (wq.size() > 0) && (wq[0] == n);
        chk("wr_done", wrd_o[n], e);
        e = rd_v && (rq.size() > 0) && (rq[0] == n);
        chk("rd_v", rdv_o[n], e);
      end
      chk("quiesce_done", qdone, m_mode == 2);
      chk("err", err, m_err);

      // scoreboard retirement
      for (int n = 0; n < 2; n++) begin
        if (wrd_o[n]) begin
          chk("wr_done_owed", exp_wr[n] > 0, 1);
          if (exp_wr[n] > 0) exp_wr[n]--;
        end
        if (rdv_o[n] && rrdy[n]) begin
          if (n == 0 && exp_rd0.size() > 0) chk("rd_data_r0", rdd_o[0], exp_rd0.pop_front());
          else if (n == 1 && exp_rd1.size() > 0) chk("rd_data_r1", rdd_o[1], exp_rd1.pop_front());
          else chk("rd_owed", 0, 1);
        end
      end
      // scoreboard expectations from requester-side acceptance
      for (int n = 0; n < 2; n++) begin
        acc[n] = rdy_o[n] && rv[n];
        if (acc[n]) begin
          if (rw[n]) exp_wr[n]++;
          else if (n == 0) exp_rd0.push_back(hash(ra[0]));
          else exp_rd1.push_back(hash(ra[1]));
        end
      end
      // bridge model
      if (cmd_v_o && cmd_ready) begin
        if (cmd_w_o) bw++;
        else br.push_back(cmd_addr_o);
      end
      if (wr_done_v && bw > 0) bw--;
      if (rd_v && rd_ready_o && br.size() > 0) void'(br.pop_front());

      // reference model advance
      if (wr_done_v) begin
        if (wq.size() == 0) m_err = 1'b1; else void'(wq.pop_front());
      end
      if (rd_v) begin
        if (rq.size() == 0) m_err = 1'b1; else if (erd) void'(rq.pop_front());
      end
      if (hs) begin
        if (rw[s]) wq.push_back(s); else rq.push_back(s);
        m_last = s;
      end
      m_lock = ev && !cmd_ready;
      if (m_lock) m_lock_id = s;
      case (m_mode)
        0: if (quiesce && !m_lock) m_mode = 1;
        1: if (!quiesce) m_mode = 0; else if (wq.size() == 0 && rq.size() == 0) m_mode = 2;
        default: if (!quiesce) m_mode = 0;
      endcase
    end
  end

  task automatic drive_cycle();
    for (int n = 0; n < 2; n++) begin
      if (!rv[n] || acc[n]) begin
        rv[n]  = !stop_new && ($urandom_range(0, 2) != 0);
        rw[n]  = 1'($urandom_range(0, 1));
        ra[n]  = {$urandom, $urandom};
        rdt[n] = {$urandom, $urandom};
        rsz[n] = 3'($urandom_range(0, 7));
      end
      rrdy[n] = $urandom_range(0, 3) != 0;
    end
    cmd_ready = $urandom_range(0, 2) != 0;
    wr_done_v = force_wr || (bw > 0 && $urandom_range(0, 1) == 1);
    rd_v      = (br.size() > 0) && ($urandom_range(0, 1) == 1);
    rd_data   = rd_v ? hash(br[0]) : {$urandom, $urandom};
  endtask

  task automatic drain_all(input string nm);
    int w = 0;
    stop_new = 1'b1;
    quiesce  = 1'b0;
    while ((bw > 0 || br.size() > 0 || rv[0] || rv[1]) && w < 2000) begin
      @(posedge clk); #1; drive_cycle(); w++;
    end
    repeat (2) begin @(posedge clk); #1; wr_done_v = 1'b0; rd_v = 1'b0; end
    chk({nm, "_timeout"}, w < 2000, 1);
    chk({nm, "_wr_owed"}, exp_wr[0] + exp_wr[1], 0);
    chk({nm, "_rd_owed"}, exp_rd0.size() + exp_rd1.size(), 0);
  endtask

  initial begin
    rv[0] = 1'b1; rv[1] = 1'b1; rw[0] = 1'b1; rw[1] = 1'b0;
    ra[0] = 64'h8000_0000; ra[1] = 64'h1234; rdt[0] = 64'hAA; rdt[1] = 64'hBB;
    rsz[0] = 3'd7; rsz[1] = 3'd3; rrdy[0] = 1'b1; rrdy[1] = 1'b1;
    cmd_ready = 1'b1; wr_done_v = 1'b0; rd_v = 1'b0; rd_data = 64'hFF; quiesce = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      quiesce = (c % 500) >= 380;
      drive_cycle();
    end
    drain_all("drain1");

    // response with nothing outstanding: sticky error
    @(posedge clk); #1; force_wr = 1'b1; drive_cycle();
    @(posedge clk); #1; force_wr = 1'b0; drive_cycle();
    repeat (4) begin @(posedge clk); #1; drive_cycle(); end
    chk("err_sticky", err, 1);
    chk("err_no_done_pulse_r0", wrd_o[0], 0);

    // asynchronous reset in the middle of traffic
    stop_new = 1'b0;
    for (int c = 0; c < 30; c++) begin @(posedge clk); #1; drive_cycle(); end
    @(posedge clk); #3;
    rst_n = 1'b0; wr_done_v = 1'b0; rd_v = 1'b0;
    #1;
    chk("async_reset_outputs", any_out(), 0);
    chk("async_reset_err_clear", err, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      quiesce = (c % 300) >= 200;
      drive_cycle();
    end
    drain_all("drain2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
